// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter with per-requester lock in front of a
// single synchronous-read data memory shared by the cpu core (requester 0)
// and the loader/debug port (requester 1).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic                  lock0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t state, state_n;
  logic   prio, prio_n;
  logic   arb_g0, arb_g1;

  // Arbitration and next-state: round-robin in IDLE, owner-only while locked
  always_comb begin
    arb_g0  = 1'b0;
    arb_g1  = 1'b0;
    state_n = state;
    prio_n  = prio;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !prio)) begin
          arb_g0  = 1'b1;
          prio_n  = 1'b1;
          state_n = lock0 ? LOCK0 : IDLE;
        end else if (req1) begin
          arb_g1  = 1'b1;
          prio_n  = 1'b0;
          state_n = lock1 ? LOCK1 : IDLE;
        end
      end
      LOCK0: begin
        if (req0) begin
          arb_g0  = 1'b1;
          state_n = lock0 ? LOCK0 : IDLE;
        end else begin
          state_n = IDLE;
        end
      end
      LOCK1: begin
        if (req1) begin
          arb_g1  = 1'b1;
          state_n = lock1 ? LOCK1 : IDLE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Grants are suppressed while reset is asserted, which also idles the memory port
  assign gnt0 = arb_g0 & rst_n;
  assign gnt1 = arb_g1 & rst_n;

  // State, priority and one-cycle read-response pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prio    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      state   <= state_n;
      prio    <= prio_n;
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
    end
  end

  // Memory port follows the granted requester; all zero when nobody is granted
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_data = wdata0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_data = wdata1;
    end
  end

  assign rdata = mem_in;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous-read data memory (addr in cycle N, data on mem_in in cycle N+1) between two requesters.
  - Requester 0: cpu core.
  - Requester 1: loader/debug port that fills or inspects memory.
- Round-robin arbitration with a per-requester lock, so a multi-cycle sequence (read pointer, then access through it) runs without interleaving.
- Sits between the requesters and the memory; the memory port is driven only by this block.

Parameters:
- ADDR_WIDTH, 6, memory address width.
- DATA_WIDTH, 16, memory data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0  input  1  requester 0 wants an access this cycle.
- we0  input  1  requester 0: 1 = write, 0 = read.
- lock0  input  1  requester 0 keeps ownership after this grant.
- addr0  input  ADDR_WIDTH  requester 0 address.
- wdata0  input  DATA_WIDTH  requester 0 write data.
- gnt0  output  1  requester 0 access performed this cycle.
- rvalid0  output  1  rdata holds requester 0 read result.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1: same as above, for requester 1.
- rdata  output  DATA_WIDTH  read data, shared by both requesters.
- mem_in  input  DATA_WIDTH  memory read data.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_data  output  DATA_WIDTH  memory write data.

Behaviour:
- Registered state:
  - FSM state: IDLE, LOCK0, LOCK1.
  - prio bit: 0 or 1.
  - rvalid0, rvalid1.
- Reset, asynchronous: state = IDLE, prio = 0, rvalid0 = rvalid1 = 0.
  - gnt0, gnt1 are forced to 0 while rst_n = 0.
  - With no grant, mem_we, mem_addr and mem_data are all 0.
- Grants are combinational from state, prio and req* in the same cycle. The memory port is muxed combinationally from the granted requester.
- At most one gnt is high per cycle. A requester holds req and its operands stable until it sees gnt.
- IDLE:
  - Only reqX = 1: grant X.
  - Both requesting: grant the requester equal to prio.
  - Any grant from IDLE sets prio to the non-winner on the next edge.
  - If the winner has lockX = 1 in the grant cycle, next state is LOCKX; otherwise stay in IDLE.
  - Neither requesting: no grant, state and prio unchanged.
- LOCKX:
  - Only X can be granted; the other requester is held off (gnt 0) even if requesting.
  - reqX = 1: grant X. If lockX = 0 in that cycle, next state is IDLE; otherwise stay in LOCKX.
  - reqX = 0: no grant, next state is IDLE. The other requester is served from the following cycle.
  - prio is not modified in LOCK states.
- Write: mem_we = 1 in the grant cycle; memory captures on that edge; no response.
- Read: mem_we = 0 in the grant cycle.
  - rvalidX is set on the next edge; rvalidX <= gntX & ~weX every cycle, so it is a 1-cycle pulse.
  - rdata = mem_in combinationally, meaningful only while some rvalid is high.
- Back-to-back: reads and writes from either requester may be granted every cycle.
  - A read pulse (rvalid) overlaps the next grant cycle.
- Reset mid-lock: returns to IDLE with prio = 0; in-flight rvalid is cleared.
- No address or width checking; addresses pass through unchanged.

Test Plan:
1. Single requester: req0 read addr 8 (mem[8] = 0x7123) -> gnt0 same cycle, mem_addr = 8, mem_we = 0; next cycle rvalid0 = 1, rdata = 0x7123; gnt1 and rvalid1 stay 0.
2. Contention, round-robin: req0 and req1 held high for 4 cycles, no lock, after reset -> grants in order 0, 1, 0, 1; prio toggles each cycle.
3. Lock: req0 with lock0 = 1 for 2 grants, then lock0 = 0 on the 3rd, with req1 held high throughout -> gnt0 for 3 consecutive cycles, gnt1 = 0 until the 4th cycle, then gnt1.
4. Lock release by dropping req: in LOCK1, req1 drops to 0 while req0 = 1 -> one idle cycle with no grant, then gnt0 next cycle.
5. Write then read: req1 write addr 5, data 0xABCD, followed by req0 read addr 5 -> mem_we = 1 in cycle 1; gnt0 in cycle 2; rvalid0 with rdata = 0xABCD in cycle 3.
6. Reset mid-lock: assert rst_n = 0 asynchronously while in LOCK0 with rvalid0 = 1 -> gnt*, rvalid*, mem_we go to 0 immediately; after release, contention grants requester 0 first.
